// File: rtl/compositor_pkg.sv
// Shared types and helpers for the frame compositor.
//   rgb_t          : packed {r,g,b} pixel, COLOR_BITS per channel
//   RGB_BLACK      : all-zero pixel used for blanking
//   sync_inactive  : inactive level of a sync line given its active polarity
package compositor_pkg;

    localparam int unsigned COLOR_BITS = 4;

    typedef struct packed {
        logic [COLOR_BITS-1:0] r;
        logic [COLOR_BITS-1:0] g;
        logic [COLOR_BITS-1:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '0;

    function automatic logic sync_inactive(input logic pol);
        return ~pol;
    endfunction

endpackage

// File: rtl/frame_compositor_mux.sv
// Combinational priority selector for one pixel.
//   vis         : per-layer visible flags, index 0 wins
//   layer_color : per-layer colours
//   bg_color    : colour used when no layer is visible
//   display_on  : forces black outside the visible area
//   rgb         : selected colour
module layer_priority_mux
    import compositor_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 4
) (
    input  logic [NUM_LAYERS-1:0] vis,
    input  rgb_t [NUM_LAYERS-1:0] layer_color,
    input  rgb_t                  bg_color,
    input  logic                  display_on,
    output rgb_t                  rgb
);

    logic found;

    always_comb begin
        rgb   = bg_color;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (vis[i] && !found) begin
                rgb   = layer_color[i];
                found = 1'b1;
            end
        end
        if (!display_on) begin
            rgb = RGB_BLACK;
        end
    end

endmodule

// File: rtl/frame_compositor.sv
// Pixel compositor between the sync generator / sprite layers and the VGA pins.
// Registers all inputs, resolves layer priority with blink and enable, delays
// colour and syncs by PIPE_STAGES cycles, and publishes a pairwise collision
// matrix once per frame (on the inactive-to-active vsync edge).
//   clk, reset          : pixel clock, synchronous active-high reset
//   display_on          : visible-area flag
//   hsync_in, vsync_in  : raw syncs (active level SYNC_ACTIVE)
//   layer_px            : per-layer pixel-on mask
//   layer_enable        : per-layer enable
//   blink_mask          : per-layer blink enable
//   layer_color         : per-layer colour {r,g,b}
//   bg_color            : background colour {r,g,b}
//   vga_r/g/b           : composited colour
//   vga_hs, vga_vs      : delayed syncs
//   collision_mask      : [i][j] set when layers i and j overlapped last frame
//   collision_valid     : one-cycle pulse when collision_mask updates
// COLOR_BITS must match compositor_pkg::COLOR_BITS.
module frame_compositor
    import compositor_pkg::*;
#(
    parameter int unsigned NUM_LAYERS   = 4,
    parameter int unsigned COLOR_BITS   = compositor_pkg::COLOR_BITS,
    parameter int unsigned PIPE_STAGES  = 2,
    parameter int unsigned BLINK_FRAMES = 16,
    parameter logic        SYNC_ACTIVE  = 1'b0
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   display_on,
    input  logic                                   hsync_in,
    input  logic                                   vsync_in,
    input  logic [NUM_LAYERS-1:0]                  layer_px,
    input  logic [NUM_LAYERS-1:0]                  layer_enable,
    input  logic [NUM_LAYERS-1:0]                  blink_mask,
    input  logic [NUM_LAYERS-1:0][3*COLOR_BITS-1:0] layer_color,
    input  logic [3*COLOR_BITS-1:0]                bg_color,
    output logic [COLOR_BITS-1:0]                  vga_r,
    output logic [COLOR_BITS-1:0]                  vga_g,
    output logic [COLOR_BITS-1:0]                  vga_b,
    output logic                                   vga_hs,
    output logic                                   vga_vs,
    output logic [NUM_LAYERS-1:0][NUM_LAYERS-1:0]  collision_mask,
    output logic                                   collision_valid
);

    localparam logic INACTIVE = sync_inactive(SYNC_ACTIVE);

    // Stage 1: every input registered; everything downstream uses these.
    logic                  s1_disp;
    logic                  s1_hs;
    logic                  s1_vs;
    logic [NUM_LAYERS-1:0] s1_px;
    logic [NUM_LAYERS-1:0] s1_en;
    logic [NUM_LAYERS-1:0] s1_blink;
    rgb_t [NUM_LAYERS-1:0] s1_color;
    rgb_t                  s1_bg;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_disp  <= 1'b0;
            s1_hs    <= INACTIVE;
            s1_vs    <= INACTIVE;
            s1_px    <= '0;
            s1_en    <= '0;
            s1_blink <= '0;
            s1_color <= '0;
            s1_bg    <= RGB_BLACK;
        end else begin
            s1_disp  <= display_on;
            s1_hs    <= hsync_in;
            s1_vs    <= vsync_in;
            s1_px    <= layer_px;
            s1_en    <= layer_enable;
            s1_blink <= blink_mask;
            s1_color <= layer_color;
            s1_bg    <= bg_color;
        end
    end

    // Frame boundary, blink phase and collision accumulation
    logic                                  vs_prev;
    logic                                  frame_start;
    logic [7:0]                            frame_cnt;
    logic                                  blink_phase;
    logic [NUM_LAYERS-1:0]                 hit;
    logic [NUM_LAYERS-1:0]                 vis;
    logic [NUM_LAYERS-1:0][NUM_LAYERS-1:0] acc;

    assign frame_start = (s1_vs == SYNC_ACTIVE) && (vs_prev != SYNC_ACTIVE);
    // Collisions ignore blink so hidden layers still register overlaps.
    assign hit = s1_px & s1_en;
    assign vis = hit & ~(s1_blink & {NUM_LAYERS{blink_phase}});

    always_ff @(posedge clk) begin
        if (reset) begin
            vs_prev         <= INACTIVE;
            frame_cnt       <= '0;
            blink_phase     <= 1'b0;
            acc             <= '0;
            collision_mask  <= '0;
            collision_valid <= 1'b0;
        end else begin
            vs_prev         <= s1_vs;
            collision_valid <= frame_start;
            if (frame_start) begin
                collision_mask <= acc;
                acc            <= '0;
                if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end else if (s1_disp) begin
                for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                    for (int unsigned j = 0; j < NUM_LAYERS; j++) begin
                        if (i != j && hit[i] && hit[j]) begin
                            acc[i][j] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    rgb_t mux_rgb;

    layer_priority_mux #(
        .NUM_LAYERS(NUM_LAYERS)
    ) u_mux (
        .vis        (vis),
        .layer_color(s1_color),
        .bg_color   (s1_bg),
        .display_on (s1_disp),
        .rgb        (mux_rgb)
    );

    // Remaining PIPE_STAGES-1 stages; with one stage the mux drives the pins.
    rgb_t out_rgb;
    logic out_hs;
    logic out_vs;

    if (PIPE_STAGES == 1) begin : g_direct
        always_comb begin
            out_rgb = mux_rgb;
            out_hs  = s1_hs;
            out_vs  = s1_vs;
        end
    end else begin : g_pipe
        rgb_t rgb_q [PIPE_STAGES-1];
        logic hs_q  [PIPE_STAGES-1];
        logic vs_q  [PIPE_STAGES-1];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int unsigned k = 0; k < PIPE_STAGES - 1; k++) begin
                    rgb_q[k] <= RGB_BLACK;
                    hs_q[k]  <= INACTIVE;
                    vs_q[k]  <= INACTIVE;
                end
            end else begin
                rgb_q[0] <= mux_rgb;
                hs_q[0]  <= s1_hs;
                vs_q[0]  <= s1_vs;
                for (int unsigned k = 1; k < PIPE_STAGES - 1; k++) begin
                    rgb_q[k] <= rgb_q[k-1];
                    hs_q[k]  <= hs_q[k-1];
                    vs_q[k]  <= vs_q[k-1];
                end
            end
        end

        always_comb begin
            out_rgb = rgb_q[PIPE_STAGES-2];
            out_hs  = hs_q[PIPE_STAGES-2];
            out_vs  = vs_q[PIPE_STAGES-2];
        end
    end

    assign vga_r  = out_rgb.r;
    assign vga_g  = out_rgb.g;
    assign vga_b  = out_rgb.b;
    assign vga_hs = out_hs;
    assign vga_vs = out_vs;

endmodule

// File: tb/tb_frame_compositor.sv
// Directed bench for frame_compositor (4 layers, 2 stages, blink every 2 frames,
// active-low syncs). Inputs change 1 ns after a rising edge; outputs are
// checked at that same point, so a value seen after tick k was registered at
// edge k.
module tb_frame_compositor;

    localparam int unsigned NL = 4;
    localparam int unsigned CB = 4;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     display_on = 1'b0;
    logic                     hsync_in = 1'b1;
    logic                     vsync_in = 1'b1;
    logic [NL-1:0]            layer_px = '0;
    logic [NL-1:0]            layer_enable = '1;
    logic [NL-1:0]            blink_mask = '0;
    logic [NL-1:0][3*CB-1:0]  layer_color;
    logic [3*CB-1:0]          bg_color;
    logic [CB-1:0]            vga_r, vga_g, vga_b;
    logic                     vga_hs, vga_vs;
    logic [NL-1:0][NL-1:0]    collision_mask;
    logic                     collision_valid;
    logic [3*CB-1:0]          rgb;

    int n_assert = 0;
    int n_fail   = 0;

    assign rgb = {vga_r, vga_g, vga_b};

    always #5 clk = ~clk;

    frame_compositor #(
        .NUM_LAYERS  (NL),
        .COLOR_BITS  (CB),
        .PIPE_STAGES (2),
        .BLINK_FRAMES(2),
        .SYNC_ACTIVE (1'b0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .display_on     (display_on),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .layer_px       (layer_px),
        .layer_enable   (layer_enable),
        .blink_mask     (blink_mask),
        .layer_color    (layer_color),
        .bg_color       (bg_color),
        .vga_r          (vga_r),
        .vga_g          (vga_g),
        .vga_b          (vga_b),
        .vga_hs         (vga_hs),
        .vga_vs         (vga_vs),
        .collision_mask (collision_mask),
        .collision_valid(collision_valid)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_rgb"},   32'(rgb), 32'h0);
        check({tag, "_hs"},    32'(vga_hs), 32'h1);
        check({tag, "_vs"},    32'(vga_vs), 32'h1);
        check({tag, "_mask"},  32'(collision_mask), 32'h0);
        check({tag, "_valid"}, 32'(collision_valid), 32'h0);
    endtask

    // Two-cycle vsync pulse with display off; checks the one-cycle valid pulse,
    // the published mask and the delayed vsync.
    task automatic vpulse(input string tag, input logic [15:0] exp_mask);
        vsync_in = 1'b0;
        tick(1);
        check({tag, "_valid_pre"}, 32'(collision_valid), 32'h0);
        tick(1);
        check({tag, "_valid"}, 32'(collision_valid), 32'h1);
        check({tag, "_mask"},  32'(collision_mask), 32'(exp_mask));
        check({tag, "_vs"},    32'(vga_vs), 32'h0);
        vsync_in = 1'b1;
        tick(1);
        check({tag, "_valid_post"}, 32'(collision_valid), 32'h0);
        check({tag, "_mask_hold"},  32'(collision_mask), 32'(exp_mask));
    endtask

    task automatic blink_frame(input string tag, input bit show, input bit overlap,
                               input logic [15:0] exp_mask);
        display_on = 1'b1;
        layer_px   = 4'b0001;
        tick(2);
        check({tag, "_px"}, 32'(rgb), show ? 32'hABC : 32'h00F);
        tick(1);
        check({tag, "_px2"}, 32'(rgb), show ? 32'hABC : 32'h00F);
        if (overlap) begin
            layer_px = 4'b0011;
            tick(1);
            display_on = 1'b0;
            layer_px   = 4'b0000;
            tick(1);
            check({tag, "_ovl"}, 32'(rgb), show ? 32'hABC : 32'hF00);
        end
        display_on = 1'b0;
        layer_px   = 4'b0000;
        tick(2);
        check({tag, "_blank"}, 32'(rgb), 32'h0);
        vpulse({tag, "_fs"}, exp_mask);
    endtask

    initial begin
        layer_color[0] = 12'hABC;
        layer_color[1] = 12'hF00;
        layer_color[2] = 12'h0F0;
        layer_color[3] = 12'h123;
        bg_color       = 12'h00F;

        // Reset held 3 cycles with random inputs
        repeat (3) begin
            display_on   = 1'($urandom);
            hsync_in     = 1'($urandom);
            vsync_in     = 1'($urandom);
            layer_px     = 4'($urandom);
            layer_enable = 4'($urandom);
            blink_mask   = 4'($urandom);
            tick(1);
            chk_reset("rst");
        end
        display_on   = 1'b0;
        hsync_in     = 1'b1;
        vsync_in     = 1'b1;
        layer_px     = '0;
        layer_enable = '1;
        blink_mask   = '0;
        reset        = 1'b0;
        tick(1);
        chk_reset("rst_rel");

        // Priority
        display_on = 1'b1;
        layer_px   = 4'b0110;
        tick(1);
        check("prio_latency", 32'(rgb), 32'h0);
        tick(1);
        check("prio_l1", 32'(rgb), 32'hF00);
        layer_enable = 4'b1101;
        tick(2);
        check("prio_l2", 32'(rgb), 32'h0F0);
        layer_px = 4'b0000;
        tick(2);
        check("prio_bg", 32'(rgb), 32'h00F);
        layer_enable = '1;
        display_on   = 1'b0;
        tick(2);
        check("prio_off", 32'(rgb), 32'h0);
        vpulse("prio_fs", 16'h0240);

        // Blanking across a whole frame
        layer_px = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("blank_rgb", 32'(rgb), 32'h0);
        end
        layer_px = 4'b0000;
        vpulse("blank_fs", 16'h0000);

        // Single-pixel collision of layers 0 and 3, then a clean frame
        display_on = 1'b1;
        layer_px   = 4'b1001;
        tick(1);
        display_on = 1'b0;
        layer_px   = 4'b0000;
        tick(3);
        vpulse("coll_fs", 16'h1008);
        display_on = 1'b1;
        layer_px   = 4'b0001;
        tick(4);
        display_on = 1'b0;
        layer_px   = 4'b0000;
        tick(2);
        vpulse("clean_fs", 16'h0000);

        // Blink: restart from reset so phase and frame count are known
        reset = 1'b1;
        tick(1);
        chk_reset("rst2");
        reset      = 1'b0;
        blink_mask = 4'b0001;
        blink_frame("blink_f0", 1'b1, 1'b0, 16'h0000);
        blink_frame("blink_f1", 1'b1, 1'b0, 16'h0000);
        blink_frame("blink_f2", 1'b0, 1'b1, 16'h0012);
        blink_frame("blink_f3", 1'b0, 1'b0, 16'h0000);
        blink_frame("blink_f4", 1'b1, 1'b0, 16'h0000);
        blink_frame("blink_f5", 1'b1, 1'b0, 16'h0000);

        // hsync low 96 cycles: output low after edges 2..97
        hsync_in = 1'b0;
        tick(1);
        check("hs_lead", 32'(vga_hs), 32'h1);
        for (int k = 2; k <= 97; k++) begin
            tick(1);
            if (k == 96) hsync_in = 1'b1;
            check("hs_low", 32'(vga_hs), 32'h0);
        end
        tick(1);
        check("hs_trail", 32'(vga_hs), 32'h1);

        // Mid-frame reset after an overlap (blink phase is 1 here)
        display_on = 1'b1;
        layer_px   = 4'b0111;
        tick(2);
        check("mid_hidden", 32'(rgb), 32'hF00);
        reset = 1'b1;
        tick(1);
        chk_reset("rst_mid");
        reset    = 1'b0;
        layer_px = 4'b0001;
        tick(2);
        check("blink_restart", 32'(rgb), 32'hABC);
        display_on = 1'b0;
        layer_px   = 4'b0000;
        tick(2);
        vpulse("mid_fs", 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_compositor.md
Name: frame_compositor

Overview:
Parametrised pixel compositor between the sync generator / sprite layers and the VGA pins. Composites NUM_LAYERS one-bit layer masks into RGB by fixed priority, using a runtime per-layer palette and a background colour. Adds per-layer enable and frame-based blink. Latches a pairwise layer-collision matrix once per frame for game logic, and delays sync to stay pixel-aligned with the pipelined colour path.

Parameters:
NUM_LAYERS, 4, number of 1-bit layer inputs; index 0 has highest priority; range 2..8
COLOR_BITS, 4, bits per colour channel
PIPE_STAGES, 2, input-to-output latency in clk cycles; range 1..4
BLINK_FRAMES, 16, frames per blink half-period; range 1..255
SYNC_ACTIVE, 0, active level of hsync_in/vsync_in and vga_hs/vga_vs (0 = active-low)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
display_on  in  1  visible-area flag from the sync generator
hsync_in  in  1  raw hsync
vsync_in  in  1  raw vsync
layer_px  in  NUM_LAYERS  per-layer pixel-on mask for the current pixel
layer_enable  in  NUM_LAYERS  per-layer global enable
blink_mask  in  NUM_LAYERS  per-layer blink enable
layer_color  in  NUM_LAYERS x 3*COLOR_BITS  per-layer colour, packed {r,g,b}
bg_color  in  3*COLOR_BITS  background colour, packed {r,g,b}
vga_r, vga_g, vga_b  out  COLOR_BITS each  composited colour
vga_hs, vga_vs  out  1  delayed syncs
collision_mask  out  NUM_LAYERS x NUM_LAYERS  latched per-frame collisions; symmetric; diagonal 0
collision_valid  out  1  one-cycle pulse when collision_mask updates

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset values:
  - vga_r/g/b = 0.
  - vga_hs/vga_vs = ~SYNC_ACTIVE.
  - collision_mask = 0; collision_valid = 0.
  - Accumulator, frame counter and blink_phase = 0.
  - All pipeline registers are set to blank pixels and inactive syncs.
- Stage 1 registers all inputs: display_on, syncs, layer_px, layer_enable, blink_mask, layer_color, bg_color. All later logic uses the stage-1 values.
- Visibility: vis[i] = px[i] & enable[i] & ~(blink_mask[i] & blink_phase).
- Colour selection: output is the colour of the lowest i with vis[i]. If no layer is visible, output bg_color. If display_on=0, output 0 regardless of layers.
- Latency: colour and syncs appear exactly PIPE_STAGES cycles after input. Sync pulse widths are preserved.
- frame_start: stage-1 vsync transitions from inactive to active level, detected against a previous-value register that resets to inactive.
- If vsync is already active on the first cycle after reset, frame_start fires once. The mask published at that event is 0.
- Collision accumulation: while display_on=1, for each pair i!=j with hit[i] & hit[j], set acc[i][j] and acc[j][i]. hit[i] = px[i] & enable[i]; blink is ignored, so hidden layers still collide.
- On frame_start cycle:
  - collision_mask <= acc.
  - acc cleared to 0; a same-cycle hit cannot occur because display_on is low during vsync.
  - collision_valid = 1 for exactly that cycle.
  - collision_mask holds until the next frame_start.
- Blink timing:
  - On each frame_start, frame counter increments.
  - On the frame_start where the counter equals BLINK_FRAMES-1, the counter wraps to 0 and blink_phase toggles.
  - A new phase applies from that cycle onward, i.e. to the whole next frame.
  - BLINK_FRAMES=1 toggles every frame.
- Reset mid-frame: acc is discarded, blink restarts at phase 0, and outputs return to reset values on the next edge. In-flight pipeline pixels are lost.
- Inputs that change mid-line (layer_color, bg_color, enable) take effect per pixel at their sampled cycle. No shadowing.

Decomposition:
- Package compositor_pkg:
  - rgb_t packed struct {r,g,b} of COLOR_BITS fields; COLOR_BITS is a package localparam default 4, overridden consistently.
  - RGB_BLACK constant.
  - Function sync_inactive(pol).
- Sub-module layer_priority_mux: combinational; inputs vis, layer_color, bg_color, display_on; output rgb_t. Instantiated once, between stage 1 and the remaining pipeline stages.

Test Plan:
Config for all scenarios: NUM_LAYERS=4, PIPE_STAGES=2, COLOR_BITS=4, SYNC_ACTIVE=0, BLINK_FRAMES=2.
- Reset: hold reset=1 for 3 cycles with random inputs -> vga_rgb=0, vga_hs=vga_vs=1, collision_mask=0, collision_valid=0 throughout and on the first cycle after release.
- Priority: display_on=1, layer_px=4'b0110, color[1]=12'hF00, color[2]=12'h0F0, bg=12'h00F -> 2 cycles later rgb=F,0,0. Then clear enable[1] -> 0,F,0. Then layer_px=0 -> 0,0,F.
- Blanking: display_on=0, layer_px=4'b1111 across a whole frame -> rgb=0 every cycle; next frame_start publishes collision_mask=0 with collision_valid=1 for one cycle.
- Collision: one pixel with layer_px=4'b1001, display_on=1, then vsync_in falls -> exactly one cycle of collision_valid. collision_mask[0][3]=collision_mask[3][0]=1, all other bits 0. A following clean frame publishes mask 0.
- Blink: blink_mask=4'b0001, layer0 on every visible pixel for 6 frames -> layer0 colour visible in frames 0-1, background in 2-3, visible in 4-5. A layer0/layer1 overlap during frame 2 still sets mask[0][1].
- Sync alignment and reset: hsync_in low for 96 cycles starting at cycle N -> vga_hs low for cycles N+2..N+97. Asserting reset mid-frame after an overlap means the next frame's published mask excludes that pre-reset overlap.
